// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of N_IN input FIFOs into one output FIFO, up to MAX_BURST items per grant.
// Latency: 1 cycle from IDLE to grant; each item moves head->output in the same cycle it is popped.
// Backpressure: out_full freezes the owner in place (grant kept, burst count held, no strobes).
//
// Ports: clk, reset (synchronous, active-low); enable allows new grants; in_empty/in_item are
// the input FIFO flags and head items (input i at [i*DATA_W +: DATA_W]); in_read pops one input;
// out_full/out_item/out_write face the output FIFO; grant_valid/grant_idx expose the owner;
// xfer_count counts every transfer and wraps.
module fifo_rr_arbiter #(
  parameter int N_IN      = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4,
  parameter int routerid  = -1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_IN-1:0]            in_empty,
  input  logic [N_IN*DATA_W-1:0]     in_item,
  output logic [N_IN-1:0]            in_read,
  input  logic                       out_full,
  output logic [DATA_W-1:0]          out_item,
  output logic                       out_write,
  output logic                       grant_valid,
  output logic [$clog2(N_IN)-1:0]    grant_idx,
  output logic [15:0]                xfer_count
);

  localparam int IDX_W = $clog2(N_IN);
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  // Elaboration-time guards on the parameter ranges the block is built for.
  if (N_IN < 2 || N_IN > 16) begin : g_bad_n_in
    $error("fifo_rr_arbiter: N_IN must be 2..16");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("fifo_rr_arbiter: MAX_BURST must be 1..255");
  end
  if (routerid < -1) begin : g_bad_id
    $error("fifo_rr_arbiter: routerid must be -1 (unassigned) or a non-negative id");
  end

  typedef enum logic [0:0] {IDLE, HOLD} state_e;

  state_e             state_q,      state_d;
  logic [IDX_W-1:0]   rr_ptr_q,     rr_ptr_d;
  logic [IDX_W-1:0]   grant_idx_q,  grant_idx_d;
  logic [7:0]         burst_cnt_q,  burst_cnt_d;
  logic [15:0]        xfer_count_q, xfer_count_d;

  logic               any_req;
  logic [N_IN-1:0]    req_rot;
  logic [IDX_W:0]     win_off;
  logic [IDX_W:0]     win_sum;
  logic [IDX_W-1:0]   winner;
  logic               owner_empty;
  logic [DATA_W-1:0]  owner_item;
  logic [IDX_W-1:0]   ptr_after_owner;
  logic               xfer;

  // Winner search: rotate the request vector so rr_ptr sits at bit 0, take the lowest set
  // bit as an offset, then add the offset back modulo N_IN (N_IN need not be a power of 2).
  always_comb begin
    any_req = |(~in_empty);
    req_rot = N_IN'({~in_empty, ~in_empty} >> rr_ptr_q);
    win_off = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (req_rot[k]) win_off = (IDX_W + 1)'(k);
    end
    win_sum = {1'b0, rr_ptr_q} + win_off;
    if (win_sum >= (IDX_W + 1)'(N_IN)) win_sum = win_sum - (IDX_W + 1)'(N_IN);
    winner = win_sum[IDX_W-1:0];
  end

  // Owner-side view: flag and head item of the input currently granted.
  always_comb begin
    owner_empty = 1'b1;
    owner_item  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        owner_empty = in_empty[i];
        owner_item  = in_item[i*DATA_W +: DATA_W];
      end
    end
    ptr_after_owner = (grant_idx_q == IDX_W'(N_IN - 1)) ? '0 : grant_idx_q + 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_idx_d  = grant_idx_q;
    burst_cnt_d  = burst_cnt_q;
    xfer_count_d = xfer_count_q;
    grant_valid  = 1'b0;
    xfer         = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && any_req) begin
          grant_idx_d = winner;
          burst_cnt_d = '0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        grant_valid = 1'b1;
        xfer        = !owner_empty && !out_full;
        if (xfer) begin
          burst_cnt_d  = burst_cnt_q + 1'b1;
          xfer_count_d = xfer_count_q + 1'b1;
        end
        // An owner that ran dry releases on the following cycle without moving an item.
        if (owner_empty || (xfer && burst_cnt_q == LAST_BEAT)) begin
          state_d  = IDLE;
          rr_ptr_d = ptr_after_owner;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are gated by reset so nothing is popped or pushed in a cycle being reset.
  always_comb begin
    in_read   = '0;
    out_write = 1'b0;
    out_item  = '0;
    if (xfer && reset) begin
      for (int i = 0; i < N_IN; i++) begin
        in_read[i] = (grant_idx_q == IDX_W'(i));
      end
      out_write = 1'b1;
      out_item  = owner_item;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_idx_q  <= '0;
      burst_cnt_q  <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_idx_q  <= grant_idx_d;
      burst_cnt_q  <= burst_cnt_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign grant_idx  = grant_idx_q;
  assign xfer_count = xfer_count_q;

endmodule
